// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester, pause and shared-counter signals of the wait-counter arbiter
interface timer_arbiter_if;
    logic       req_i;
    logic [3:0] limit_i;
    logic       req_d;
    logic [3:0] limit_d;
    logic       pause;
    logic       gnt_i;
    logic       gnt_d;
    logic       done_i;
    logic       done_d;
    logic       busy;
    logic       timer_start;
    logic [3:0] timer_limit;
    logic       timer_increment;
    logic       timer_done;
    modport master (
        output req_i, limit_i, req_d, limit_d, pause, timer_done,
        input  gnt_i, gnt_d, done_i, done_d, busy, timer_start, timer_limit, timer_increment
    );
    modport slave (
        input  req_i, limit_i, req_d, limit_d, pause, timer_done,
        output gnt_i, gnt_d, done_i, done_d, busy, timer_start, timer_limit, timer_increment
    );
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared 4-bit wait counter for I-side and D-side miss handlers
module timer_arbiter (
    input logic           clk,
    input logic           rst,
    timer_arbiter_if.slave bus
);
    typedef enum logic {IDLE, COUNT} state_t;
    state_t     state, nxt;
    logic       owner, last, win, own_req, cnt_st;
    logic [3:0] lim;
    always_comb win = (bus.req_i & bus.req_d) ? ~last : bus.req_d;
    always_comb own_req = owner ? bus.req_d : bus.req_i;
    always_comb cnt_st = (state == COUNT);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= nxt;
    // last resets to D so the I side wins the first tie
    always_ff @(posedge clk)
        if (rst) begin
            owner <= 1'b0;
            last  <= 1'b1;
            lim   <= '0;
        end else if (state == IDLE && (bus.req_i | bus.req_d)) begin
            owner <= win;
            last  <= win;
            lim   <= win ? bus.limit_d : bus.limit_i;
        end
    always_comb
        nxt = (state == IDLE) ? ((bus.req_i | bus.req_d) ? COUNT : IDLE)
                              : ((~own_req | bus.timer_done) ? IDLE : COUNT);
    always_comb begin
        bus.timer_start     = ~cnt_st;
        bus.timer_limit     = lim;
        bus.timer_increment = cnt_st & ~bus.pause & ~bus.timer_done;
        bus.busy            = cnt_st;
        bus.gnt_i           = cnt_st & ~owner;
        bus.gnt_d           = cnt_st & owner;
        bus.done_i          = cnt_st & ~owner & bus.req_i & bus.timer_done;
        bus.done_d          = cnt_st & owner & bus.req_d & bus.timer_done;
    end
endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Controller that shares one 4-bit wait counter (start/limit/increment/done interface) between two requesters: the instruction-side and data-side memory-miss handlers. It grants the counter to one requester at a time, with round-robin on ties. It clears and loads the counter, drives its increment, and returns a one-cycle completion pulse to the owner. It sits between the cache-miss FSMs and the single shared counter instance in the memory stage.

## Interface
- No parameters; all widths are fixed at 4 bits to match the counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  1  I-side wait request; held high until done_i or intentionally dropped (abort).
- limit_i  in  4  I-side wait length; sampled only in the grant cycle.
- req_d  in  1  D-side wait request, same rules as req_i.
- limit_d  in  4  D-side wait length.
- pause  in  1  freezes counting while high (pipeline-wide freeze).
- gnt_i  out  1  high while I-side owns the counter (state COUNT, owner=I).
- gnt_d  out  1  high while D-side owns the counter.
- done_i  out  1  one-cycle pulse: I-side wait complete.
- done_d  out  1  one-cycle pulse: D-side wait complete.
- busy  out  1  high in COUNT.
- timer_start  out  1  to counter start; clears count to 0.
- timer_limit  out  4  to counter limit; latched limit of the current owner.
- timer_increment  out  1  to counter increment.
- timer_done  in  1  from counter; count == limit.

## Operation
- State register, two states:
  - IDLE: the counter is held cleared.
  - COUNT: the owner's wait is in progress.
- Registers:
  - state
  - owner: 1 bit, 0 = I, 1 = D
  - lim: 4 bits
  - last: 1 bit, owner of the most recent grant
- IDLE outputs:
  - timer_start=1, timer_increment=0.
  - gnt_*=0, done_*=0, busy=0.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only req_i: owner<=I, lim<=limit_i, last<=I, go to COUNT.
  - Only req_d: the D-side equivalent.
  - Both requests: winner is the requester that is not `last`; winner's limit is latched; last<=winner.
- COUNT outputs:
  - timer_start=0, timer_limit=lim.
  - timer_increment = ~pause & ~timer_done.
  - gnt_owner=1, busy=1.
- COUNT, owner's req still high and timer_done=1:
  - done_owner=1 for this cycle only.
  - Next state IDLE.
- COUNT, owner's req low (abort):
  - Next state IDLE; no done pulse, regardless of timer_done.
  - The non-owner request is ignored throughout COUNT.
- Limit change mid-wait: changes on limit_i/limit_d during COUNT have no effect, because lim is latched.
- Count behaviour:
  - count starts at 0 on entering COUNT and rises by 1 per unpaused COUNT cycle.
  - It stops at lim; it never wraps.
- lim=0: timer_done is high in the first COUNT cycle, so done fires immediately.
- Reset:
  - state=IDLE, owner=I, lim=0, last=D, so the I side wins the first tie.
  - All outputs take their IDLE values in the cycle after rst is sampled.
  - This applies equally when rst is asserted mid-COUNT: no done pulse, and the counter is re-cleared via timer_start.

## Timing
- Cycle 0 (IDLE, req sampled): grant decision is made.
- Cycle 1 onward (COUNT): gnt high.
- With no pause, done_owner is at cycle 1+lim, and gnt falls the same cycle after it.
- Each paused cycle delays done by 1.
- Minimum one IDLE cycle between consecutive grants: after done at cycle N, the next grant is visible at cycle N+2.
- All outputs are combinational from the registers plus req/pause/timer_done.
  - No output depends on limit_* combinationally.
  - done_* and timer_increment depend on timer_done within the same cycle.

## Test plan
- **Single I wait:** after reset, req_i=1 with limit_i=3 at cycle 0.
  - gnt_i is high for cycles 1–4.
  - done_i pulses at cycle 4.
  - The counter sees timer_start=0 from cycle 1.
- **Tie round-robin:** req_i=req_d=1 continuously, limit_i=2, limit_d=1.
  - Grant order I, D, I, D.
  - done_i at cycle 3, done_d at cycle 6, done_i at cycle 10.
- **lim=0 and pause:**
  - req_d with limit_d=0: done_d at cycle 1.
  - Then req_d with limit_d=2 and pause high for 2 cycles mid-wait: done_d is 2 cycles later than unpaused.
- **Abort:** req_i with limit_i=5, drop req_i at cycle 3.
  - No done_i.
  - IDLE at cycle 4.
  - A pending req_d is granted at cycle 5.
- **Latch check:** during an I wait with limit_i=4, change limit_i to 1 at cycle 2.
  - done_i still at cycle 5.
- **Reset mid-count:** assert rst at cycle 2 of a D wait with limit_d=6.
  - All outputs return to IDLE values; no done_d.
  - A following tie grants I first.
